// File: rtl/eth10_pkg.sv
// rtl/eth10_pkg.sv - shared 10BASE-T link pulse state type and timing defaults
package eth10_pkg;

  typedef enum logic [1:0] {
    LINK_FAIL,
    LINK_CHECK,
    LINK_PASS
  } link_state_t;

  localparam int NLP_PW_MAX       = 10;
  localparam int NLP_MIN_INTERVAL = 100000;
  localparam int NLP_MAX_INTERVAL = 2500000;
  localparam int NLP_LC_MAX       = 4;

endpackage

// File: rtl/nlp_pulse_qual.sv
// rtl/nlp_pulse_qual.sv - rx synchronizer, pulse width counter and falling-edge qualification
module nlp_pulse_qual #(
  parameter int PW_MIN = 1,
  parameter int PW_MAX = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic pulse_det,
  output logic wide
);

  localparam int              WW    = $clog2(PW_MAX + 2);
  localparam logic [WW-1:0]   W_SAT = WW'(PW_MAX + 1);
  localparam logic [WW-1:0]   W_MIN = WW'(PW_MIN);
  localparam logic [WW-1:0]   W_MAX = WW'(PW_MAX);

  logic          rx_m;
  logic          rx_s;
  logic          rx_s_d;
  logic [WW-1:0] width;
  logic          fall;
  logic          in_range;

  assign fall     = ~rx_s & rx_s_d;
  assign in_range = (width >= W_MIN) && (width <= W_MAX);

  // width holds the full high time of rx_s in the cycle the falling edge is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m      <= 1'b0;
      rx_s      <= 1'b0;
      rx_s_d    <= 1'b0;
      width     <= '0;
      pulse_det <= 1'b0;
      wide      <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_s_d    <= rx_s;
      if (!rx_s)
        width <= '0;
      else if (width != W_SAT)
        width <= width + WW'(1);
      pulse_det <= fall & in_range;
      wide      <= fall & ~in_range;
    end
  end

endmodule

// File: rtl/nlp_detector.sv
// rtl/nlp_detector.sv - 10BASE-T normal link pulse detector with link-integrity FSM
module nlp_detector
  import eth10_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int PW_MIN       = 1,
  parameter int PW_MAX       = NLP_PW_MAX,
  parameter int MIN_INTERVAL = NLP_MIN_INTERVAL,
  parameter int MAX_INTERVAL = NLP_MAX_INTERVAL,
  parameter int LC_MAX       = NLP_LC_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       pulse_det,
  output logic       link_up,
  output logic       link_lost,
  output logic [3:0] link_count
);

  localparam int            TW    = $clog2(MAX_INTERVAL + 1);
  localparam logic [TW-1:0] T_MAX = TW'(MAX_INTERVAL);
  localparam logic [TW-1:0] T_MIN = TW'(MIN_INTERVAL);
  localparam logic [3:0]    LC    = 4'(LC_MAX);

  if (CLK_FREQ < 1) begin : g_clk_freq_unset
  end

  logic          wide;
  link_state_t   state;
  link_state_t   state_next;
  logic [TW-1:0] timer;
  logic          timer_clr;
  logic [3:0]    count_next;
  logic          up_next;
  logic          lost_next;
  logic          timeout;
  logic          in_window;

  nlp_pulse_qual #(
    .PW_MIN (PW_MIN),
    .PW_MAX (PW_MAX)
  ) u_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .pulse_det (pulse_det),
    .wide      (wide)
  );

  assign timeout   = (timer == T_MAX);
  assign in_window = (timer >= T_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (timer_clr)
      timer <= '0;
    else if (timer != T_MAX)
      timer <= timer + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LINK_FAIL;
      link_count <= 4'd0;
      link_up    <= 1'b0;
      link_lost  <= 1'b0;
    end else begin
      state      <= state_next;
      link_count <= count_next;
      link_up    <= up_next;
      link_lost  <= lost_next;
    end
  end

  // A timeout coinciding with a strobe counts the strobe as the first pulse after FAIL
  always_comb begin
    state_next = state;
    count_next = link_count;
    timer_clr  = 1'b0;
    unique case (state)
      LINK_FAIL: begin
        if (pulse_det) begin
          state_next = LINK_CHECK;
          count_next = 4'd1;
          timer_clr  = 1'b1;
        end
      end
      LINK_CHECK, LINK_PASS: begin
        if (timeout) begin
          state_next = pulse_det ? LINK_CHECK : LINK_FAIL;
          count_next = pulse_det ? 4'd1 : 4'd0;
          timer_clr  = pulse_det;
        end else if (state == LINK_PASS) begin
          timer_clr = pulse_det & in_window;
        end else if (pulse_det) begin
          timer_clr = 1'b1;
          if (in_window) begin
            count_next = (link_count == LC) ? LC : link_count + 4'd1;
            if (count_next == LC)
              state_next = LINK_PASS;
          end else begin
            count_next = 4'd1;
          end
        end else if (wide) begin
          count_next = 4'd0;
        end
      end
      default: begin
        state_next = LINK_FAIL;
        count_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    up_next   = (state_next == LINK_PASS);
    lost_next = (state == LINK_PASS) && timeout;
  end

endmodule

// File: tb/tb_nlp_detector.sv
// tb/tb_nlp_detector.sv - scoreboard bench for nlp_detector with short sim timing
module tb_nlp_detector;

  localparam int PW_MAX  = 4;
  localparam int MIN_INT = 20;
  localparam int MAX_INT = 100;
  localparam int LC_MAX  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       pulse_det;
  logic       link_up;
  logic       link_lost;
  logic [3:0] link_count;

  typedef struct {
    int cyc;
    int cnt;
    bit up;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   lost_seen = 0;
  int   last_det = 0;

  nlp_detector #(
    .CLK_FREQ     (50000000),
    .PW_MIN       (1),
    .PW_MAX       (PW_MAX),
    .MIN_INTERVAL (MIN_INT),
    .MAX_INTERVAL (MAX_INT),
    .LC_MAX       (LC_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .pulse_det  (pulse_det),
    .link_up    (link_up),
    .link_lost  (link_lost),
    .link_count (link_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: rx is sampled for w rising edges; strobe lands w+3 edges later
  task automatic send(input int w, input bit det, input int ecnt, input bit eup);
    exp_t e;
    e.cyc = cyc + w + 3;
    e.cnt = ecnt;
    e.up  = eup;
    rx = 1'b1;
    if (det) sb.push_back(e);
    repeat (w) @(negedge clk);
    rx = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_lost(input string tag);
    int t0;
    t0 = cyc;
    while (link_lost !== 1'b1 && cyc < t0 + 300) @(negedge clk);
    chk({tag, "_lost_seen"}, link_lost, 1);
    chk({tag, "_lost_delay"}, cyc - last_det, MAX_INT + 2);
    chk({tag, "_up_at_lost"}, link_up, 0);
    chk({tag, "_count_at_lost"}, link_count, 0);
    @(negedge clk);
    chk({tag, "_lost_one_cycle"}, link_lost, 0);
  endtask

  initial begin : monitor
    exp_t pend;
    bit   have_pend;
    have_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_pend = 1'b0;
      end else begin
        if (have_pend) begin
          chk("count_after_det", link_count, pend.cnt);
          chk("up_after_det", link_up, pend.up);
          have_pend = 1'b0;
        end
        if (pulse_det) begin
          if (sb.size() == 0) begin
            chk("unexpected_det", 1, 0);
          end else begin
            pend = sb.pop_front();
            chk("det_cycle", cyc, pend.cyc);
            have_pend = 1'b1;
            last_det  = cyc;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (link_lost === 1'b1) lost_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int b;
    int s;
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulse_det", pulse_det, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_link_lost", link_lost, 0);
    chk("rst_link_count", link_count, 0);
    rst_n = 1'b1;

    // idle line
    repeat (200) @(negedge clk);
    chk("idle_link_up", link_up, 0);
    chk("idle_link_count", link_count, 0);
    chk("idle_lost", lost_seen, 0);

    // three in-window pulses bring the link up
    t = cyc;
    send(1, 1, 1, 0);
    wait_until(t + 50);  send(1, 1, 2, 0);
    wait_until(t + 100); send(1, 1, 3, 1);
    wait_until(t + 110);
    chk("up_after_three", link_up, 1);

    // silence after PASS
    wait_lost("s3");

    // too-close pulse in CHECK restarts the count
    t = cyc;
    send(1, 1, 1, 0);
    wait_until(t + 50);  send(1, 1, 2, 0);
    wait_until(t + 60);  send(1, 1, 1, 0);
    wait_until(t + 110); send(1, 1, 2, 0);
    wait_until(t + 160); send(1, 1, 3, 1);
    wait_until(t + 170);
    chk("s4_up", link_up, 1);
    wait_lost("s4");

    // wide pulse in CHECK clears the count; following 4-clk pulse is too close
    t = cyc;
    send(1, 1, 1, 0);
    b = t + 50;
    wait_until(b);       send(1, 1, 2, 0);
    wait_until(b + 5);   send(6, 0, 0, 0);
    wait_until(b + 14);
    chk("wide_count_before", link_count, 2);
    chk("wide_no_det", pulse_det, 0);
    wait_until(b + 15);
    chk("wide_count_cleared", link_count, 0);
    wait_until(b + 16);  send(4, 1, 1, 0);
    wait_until(b + 30);
    chk("s5_up", link_up, 0);

    // steady pulses through PASS with an asynchronous reset in the middle
    s = b + 46;
    for (int i = 0; i < 33; i++) begin
      wait_until(s + 30 * i);
      if (i < 16)
        send(1, 1, (i + 2 > LC_MAX) ? LC_MAX : i + 2, i >= 1);
      else
        send(1, 1, (i - 15 > LC_MAX) ? LC_MAX : i - 15, i >= 18);
      if (i == 15) begin
        wait_until(s + 30 * i + 10);
        chk("pre_rst_up", link_up, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_up", link_up, 0);
        chk("async_rst_count", link_count, 0);
        chk("async_rst_det", pulse_det, 0);
        chk("async_rst_lost", link_lost, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    wait_until(s + 30 * 32 + 10);
    chk("final_up", link_up, 1);
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
